// File: rtl/onchip_mem_arbiter.sv
// Purpose: shares one single-port 64K x 32 RAM between the Nios data master (m0) and the SD DMA master (m1).
// Latency: access issues in the grant cycle; read data and readdatavalid return exactly one cycle later.
// Backpressure: the losing requester sees waitrequest until granted; reset stalls both ports.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic [31:0]       m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic [31:0]       m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);

    // The current owner may keep the RAM while hold_cnt is below this limit.
    localparam logic [3:0] HOLD_LIM = 4'(BURST_MAX - 1);
    localparam logic [3:0] HOLD_SAT = 4'd15;

    // Decoded requests; read+write together counts as a write.
    logic req0;
    logic req1;
    logic wr0;
    logic wr1;

    // Arbitration history. last_grant/rd_owner: 0 = m0, 1 = m1.
    // arb_fresh marks "no grant since reset": the first winner then starts a
    // new burst, and with last_grant = 1 a first contention goes to m0.
    logic       last_grant;
    logic [3:0] hold_cnt;
    logic       arb_fresh;

    // Outstanding read response (RAM q is valid one cycle after issue).
    logic rd_pend;
    logic rd_owner;

    // Grant for the current cycle.
    logic grant_vld;
    logic grant_sel;
    logic keep_last;
    logic grant0;
    logic grant1;
    logic win_wr;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign wr0  = m0_write;
    assign wr1  = m1_write;

    // Pick the winner: lone requester wins; on contention the last owner keeps
    // the RAM until its burst allowance is used up, then the other side gets it.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        keep_last = ~arb_fresh & (hold_cnt < HOLD_LIM);
        if (reset_n) begin
            if (req0 && req1) begin
                grant_vld = 1'b1;
                grant_sel = keep_last ? last_grant : ~last_grant;
            end else if (req0) begin
                grant_vld = 1'b1;
                grant_sel = 1'b0;
            end else if (req1) begin
                grant_vld = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign grant0 = grant_vld & ~grant_sel;
    assign grant1 = grant_vld &  grant_sel;
    assign win_wr = grant_sel ? wr1 : wr0;

    // Drive the RAM from the winner; with no winner the bus parks on m0's values.
    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
        mem_chipselect = grant_vld;
        mem_write      = grant_vld & win_wr;
        mem_clken      = reset_n;
    end

    // Stall the loser; both ports stall while reset is held.
    always_comb begin
        m0_waitrequest = ~reset_n | (req0 & ~grant0);
        m1_waitrequest = ~reset_n | (req1 & ~grant1);
    end

    // Track who owns the RAM and how many consecutive grants it has had.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            hold_cnt   <= 4'd0;
            arb_fresh  <= 1'b1;
        end else if (grant_vld) begin
            if (!arb_fresh && (grant_sel == last_grant)) begin
                if (hold_cnt != HOLD_SAT) begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end else begin
                hold_cnt <= 4'd0;
            end
            last_grant <= grant_sel;
            arb_fresh  <= 1'b0;
        end
    end

    // Remember a granted read so its data can be steered back next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= grant_vld & ~win_wr;
            if (grant_vld && !win_wr) begin
                rd_owner <= grant_sel;
            end
        end
    end

    // Read data is broadcast; only the owner's valid qualifies it.
    always_comb begin
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = rd_pend & ~rd_owner;
        m1_readdatavalid = rd_pend &  rd_owner;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-port Avalon-MM arbiter that shares the single-port 64K x 32 on-chip RAM between the Nios II data master (port m0) and the SD-card sector DMA engine (port m1).
- Issues at most one access per cycle to the RAM.
- Selects the requester by round-robin, with a bounded burst hold so DMA streams are not fragmented.
- Returns read data one cycle after issue, using a pipelined readdatavalid.

Parameters:
- ADDR_W, 16, word address width to RAM and both ports.
- BURST_MAX, 4, maximum consecutive grants to one requester while the other waits (1 = pure round-robin; legal 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  Nios word address
- m0_byteenable  in  4  Nios byte lanes
- m0_read  in  1  Nios read request
- m0_write  in  1  Nios write request
- m0_writedata  in  32  Nios write data
- m0_readdata  out  32  Nios read data
- m0_waitrequest  out  1  Nios stall
- m0_readdatavalid  out  1  Nios read data valid
- m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_readdata, m1_waitrequest, m1_readdatavalid: same widths and meanings as the m0 set, for the DMA port
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  4  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  32  RAM q, valid one cycle after the address is issued

Behaviour:
- Request decode: reqN = mN_read | mN_write. If read and write are both high on the same port, the access is treated as a write.
- Registers (all async-cleared by reset_n low):
  - last_grant (1 bit): resets to 1, so m0 wins the first contention.
  - hold_cnt (4 bits): resets to 0.
  - rd_pend: resets to 0.
  - rd_owner: resets to 0.
- Grant each cycle (combinational):
  - Only one port requesting: that port wins.
  - Both requesting: last_grant wins if hold_cnt < BURST_MAX-1; otherwise the other port wins.
  - No request: no grant.
- Issue:
  - The winner's address, byteenable and writedata drive mem_*.
  - mem_chipselect = 1.
  - mem_write = winner's decoded write.
  - With no winner: mem_chipselect = 0, mem_write = 0, and mem_address/mem_byteenable/mem_writedata hold m0's values.
  - mem_clken = reset_n (low during reset, 1 otherwise).
- waitrequest (combinational):
  - mN_waitrequest = reqN & ~grantN.
  - Outside a request, waitrequest is 0.
  - While reset_n is low, both waitrequests are 1.
- Register update on a grant to g:
  - If g == last_grant: hold_cnt = min(hold_cnt+1, 15).
  - Otherwise: hold_cnt = 0.
  - last_grant = g.
- Idle cycle: last_grant and hold_cnt are unchanged.
- Read return:
  - A granted read sets rd_pend = 1 and rd_owner = g for the next cycle; any other cycle clears rd_pend.
  - mN_readdatavalid = rd_pend & (rd_owner == N).
  - mN_readdata = mem_readdata, unconditionally on both ports.
  - Latency is fixed at 1 cycle, so back-to-back reads yield back-to-back valids.
- Writes complete in the grant cycle and produce no response.
- Reset mid-operation: a pending readdatavalid is dropped and no RAM write is issued while reset_n is low. After release, the first contention goes to m0.
- There is no ordering hazard: single port, one access per cycle, RAM read-during-write is don't-care. Masters never read and write the same address in the same cycle.

Test Plan:
- m0 alone reads address 0x0010 (RAM holds 0xDEADBEEF) -> m0_waitrequest = 0 in the issue cycle; m0_readdatavalid = 1 with m0_readdata = 0xDEADBEEF exactly one cycle later; m1_readdatavalid stays 0.
- Both ports request continuous reads from reset with BURST_MAX = 4 -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0…; each port's waitrequest is high on the other's cycles; the valid stream is unbroken.
- BURST_MAX = 1, both ports request continuous writes -> strict alternation m0,m1,m0,m1; RAM readback confirms every write, including a byteenable = 4'b0010 write that changes only bits 15:8.
- m1 holds the grant for 2 cycles, then 1 idle cycle, then both request -> m1 wins 2 more cycles (hold_cnt continues 2,3), then m0.
- m0 asserts read and write together with writedata 0x12345678 -> a RAM write is issued and no readdatavalid is produced.
- reset_n pulsed low the cycle after a granted m1 read -> m1_readdatavalid stays 0; during reset both waitrequests = 1 and mem_chipselect = 0; after release, first contention grants m0.
